// File: rtl/dbg_controller.sv
// rtl/dbg_controller.sv - debug command controller: program load, run/step, PC breakpoint, state dump
module dbg_controller #(
  parameter int NB_REG = 32,
  parameter int N_REGS = 32,
  parameter int N_MEM  = 32,
  parameter int NB_CNT = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_data,
  input  logic              i_tx_full,
  output logic              o_tx_wr,
  output logic [7:0]        o_tx_data,
  input  logic              i_halt,
  input  logic [NB_REG-1:0] i_pc,
  input  logic [NB_REG-1:0] i_reg_data,
  input  logic [NB_REG-1:0] i_mem_data,
  output logic [NB_REG-1:0] o_addr,
  output logic [NB_REG-1:0] o_inst,
  output logic              o_w_mem,
  output logic              o_enable,
  output logic              o_reset_mips
);

  localparam int                NB_BYTES  = NB_REG / 8;
  localparam logic [7:0]        LAST_BYTE = 8'(NB_BYTES - 1);
  localparam logic [NB_REG-1:0] LAST_REG  = NB_REG'(N_REGS - 1);
  localparam logic [NB_REG-1:0] LAST_MEM  = NB_REG'(N_MEM - 1);

  localparam logic [7:0] CMD_LOAD  = 8'h4C;
  localparam logic [7:0] CMD_CONT  = 8'h43;
  localparam logic [7:0] CMD_STEP  = 8'h53;
  localparam logic [7:0] CMD_STEPN = 8'h4E;
  localparam logic [7:0] CMD_BP    = 8'h42;
  localparam logic [7:0] CMD_BPCLR = 8'h62;
  localparam logic [7:0] CMD_RESET = 8'h52;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;

  typedef enum logic [3:0] {
    IDLE, GET_ARG, LOAD, RUN, STEP, DUMP_ST, DUMP_PC, DUMP_REG, DUMP_MEM, ACK
  } state_t;

  // Per-word read sequence in the register/memory dump: address settles, data captured, bytes emitted.
  typedef enum logic [1:0] {RD_WAIT, RD_CAPT, RD_EMIT} rd_t;

  state_t            state, next_state;
  rd_t               rd_phase;
  logic [7:0]        cmd;
  logic [7:0]        byte_cnt;
  logic [NB_REG-1:0] word_buf;
  logic [NB_REG-1:0] word_shift;
  logic [NB_CNT-1:0] load_idx;
  logic [NB_CNT-1:0] load_total;
  logic [NB_CNT-1:0] step_cnt;
  logic              first_cyc;
  logic              bp_en;
  logic [NB_REG-1:0] bp_addr;
  logic              stop_bp;
  logic              tx_valid;

  logic bp_hit, bp_stop, run_ok, tx_free, last_byte, dump_last_word;

  // The breakpoint is masked on the first enabled cycle so a core parked on it can resume.
  assign bp_hit     = bp_en & (i_pc == bp_addr);
  assign bp_stop    = bp_hit & ~first_cyc;
  assign run_ok     = ~i_halt & ~bp_stop;
  // One-entry TX slot: a new byte may be loaded whenever the current one leaves this cycle.
  assign o_tx_wr    = tx_valid & ~i_tx_full;
  assign tx_free    = ~tx_valid | ~i_tx_full;
  assign last_byte  = (byte_cnt == LAST_BYTE);
  assign word_shift = (word_buf << 8) | NB_REG'(i_rx_data);
  assign dump_last_word = (state == DUMP_REG) ? (o_addr == LAST_REG) : (o_addr == LAST_MEM);

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= next_state;
  end

  // Next-state decode and the combinational pipeline enable.
  always_comb begin
    next_state = state;
    o_enable   = 1'b0;
    case (state)
      IDLE: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            CMD_LOAD, CMD_STEPN, CMD_BP: next_state = GET_ARG;
            CMD_CONT:                    next_state = RUN;
            CMD_STEP:                    next_state = STEP;
            CMD_BPCLR, CMD_RESET:        next_state = ACK;
            default:                     next_state = IDLE;
          endcase
        end
      end
      GET_ARG: begin
        if (i_rx_valid) begin
          if (cmd == CMD_LOAD)       next_state = (i_rx_data == 8'h00) ? ACK : LOAD;
          else if (cmd == CMD_STEPN) next_state = (i_rx_data == 8'h00) ? DUMP_ST : STEP;
          else if (last_byte)        next_state = ACK;
        end
      end
      LOAD: begin
        if (i_rx_valid && last_byte && (load_idx == load_total - NB_CNT'(1)))
          next_state = ACK;
      end
      RUN: begin
        o_enable = run_ok;
        if (!run_ok) next_state = DUMP_ST;
      end
      STEP: begin
        o_enable = run_ok;
        if (!run_ok || (step_cnt == NB_CNT'(1))) next_state = DUMP_ST;
      end
      DUMP_ST: begin
        if (tx_free) next_state = DUMP_PC;
      end
      DUMP_PC: begin
        if (tx_free && last_byte) next_state = DUMP_REG;
      end
      DUMP_REG, DUMP_MEM: begin
        if ((rd_phase == RD_EMIT) && tx_free && last_byte && dump_last_word)
          next_state = (state == DUMP_REG) ? DUMP_MEM : IDLE;
      end
      ACK: begin
        if (tx_free) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: argument collection, load strobes, step bookkeeping, dump sequencing and TX slot.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rd_phase     <= RD_WAIT;
      cmd          <= '0;
      byte_cnt     <= '0;
      word_buf     <= '0;
      load_idx     <= '0;
      load_total   <= '0;
      step_cnt     <= '0;
      first_cyc    <= 1'b0;
      bp_en        <= 1'b0;
      bp_addr      <= '0;
      stop_bp      <= 1'b0;
      tx_valid     <= 1'b0;
      o_tx_data    <= '0;
      o_addr       <= '0;
      o_inst       <= '0;
      o_w_mem      <= 1'b0;
      o_reset_mips <= 1'b0;
    end else begin
      o_w_mem      <= 1'b0;
      o_reset_mips <= 1'b0;
      if (o_tx_wr) tx_valid <= 1'b0;

      case (state)
        IDLE: begin
          stop_bp  <= 1'b0;
          byte_cnt <= '0;
          if (i_rx_valid) begin
            cmd       <= i_rx_data;
            first_cyc <= 1'b1;
            case (i_rx_data)
              CMD_STEP:  step_cnt     <= NB_CNT'(1);
              CMD_BPCLR: bp_en        <= 1'b0;
              CMD_RESET: o_reset_mips <= 1'b1;
              CMD_LOAD, CMD_CONT, CMD_STEPN, CMD_BP: begin
              end
              default: begin
                if (tx_free) begin
                  tx_valid  <= 1'b1;
                  o_tx_data <= RSP_NAK;
                end
              end
            endcase
          end
        end
        GET_ARG: begin
          if (i_rx_valid) begin
            if (cmd == CMD_LOAD) begin
              load_total <= NB_CNT'(i_rx_data);
              load_idx   <= '0;
              byte_cnt   <= '0;
            end else if (cmd == CMD_STEPN) begin
              step_cnt <= NB_CNT'(i_rx_data);
            end else begin
              word_buf <= word_shift;
              byte_cnt <= byte_cnt + 8'd1;
              if (last_byte) begin
                bp_addr <= word_shift;
                bp_en   <= 1'b1;
              end
            end
          end
        end
        LOAD: begin
          if (i_rx_valid) begin
            word_buf <= word_shift;
            if (last_byte) begin
              byte_cnt <= '0;
              o_inst   <= word_shift;
              o_addr   <= NB_REG'(load_idx);
              o_w_mem  <= 1'b1;
              load_idx <= load_idx + NB_CNT'(1);
            end else begin
              byte_cnt <= byte_cnt + 8'd1;
            end
          end
        end
        RUN, STEP: begin
          if (o_enable) begin
            first_cyc <= 1'b0;
            step_cnt  <= step_cnt - NB_CNT'(1);
          end
          if (!run_ok) stop_bp <= bp_stop;
        end
        DUMP_ST: begin
          if (tx_free) begin
            tx_valid  <= 1'b1;
            o_tx_data <= {6'b0, stop_bp, i_halt};
            word_buf  <= i_pc;
            byte_cnt  <= '0;
          end
        end
        DUMP_PC: begin
          if (tx_free) begin
            tx_valid  <= 1'b1;
            o_tx_data <= word_buf[NB_REG-1 -: 8];
            word_buf  <= word_buf << 8;
            if (last_byte) begin
              byte_cnt <= '0;
              o_addr   <= '0;
              rd_phase <= RD_WAIT;
            end else begin
              byte_cnt <= byte_cnt + 8'd1;
            end
          end
        end
        DUMP_REG, DUMP_MEM: begin
          case (rd_phase)
            RD_WAIT: rd_phase <= RD_CAPT;
            RD_CAPT: begin
              word_buf <= (state == DUMP_REG) ? i_reg_data : i_mem_data;
              rd_phase <= RD_EMIT;
            end
            default: begin
              if (tx_free) begin
                tx_valid  <= 1'b1;
                o_tx_data <= word_buf[NB_REG-1 -: 8];
                word_buf  <= word_buf << 8;
                if (last_byte) begin
                  byte_cnt <= '0;
                  rd_phase <= RD_WAIT;
                  o_addr   <= dump_last_word ? '0 : o_addr + NB_REG'(1);
                end else begin
                  byte_cnt <= byte_cnt + 8'd1;
                end
              end
            end
          endcase
        end
        ACK: begin
          if (tx_free) begin
            tx_valid  <= 1'b1;
            o_tx_data <= RSP_ACK;
          end
        end
        default: begin
        end
      endcase

      if (next_state == IDLE) o_addr <= '0;
    end
  end

endmodule

// File: tb/tb_dbg_controller.sv
// tb/tb_dbg_controller.sv - directed self-checking bench for dbg_controller
module tb_dbg_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_full;
  logic        tx_wr;
  logic [7:0]  tx_data;
  logic        halt;
  logic [31:0] pc;
  logic [31:0] reg_rd;
  logic [31:0] mem_rd;
  logic [31:0] addr;
  logic [31:0] inst;
  logic        w_mem;
  logic        enable;
  logic        reset_mips;

  logic        halt_en;
  logic [31:0] halt_pc;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [7:0]  tx_q[$];
  logic [31:0] wm_addr[$];
  logic [31:0] wm_inst[$];
  int en_cnt  = 0;
  int rm_cnt  = 0;
  int bad_wr  = 0;

  int tx_base, en_base, rm_base, bad_base, stall_base;

  dbg_controller dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_rx_valid   (rx_valid),
    .i_rx_data    (rx_data),
    .i_tx_full    (tx_full),
    .o_tx_wr      (tx_wr),
    .o_tx_data    (tx_data),
    .i_halt       (halt),
    .i_pc         (pc),
    .i_reg_data   (reg_rd),
    .i_mem_data   (mem_rd),
    .o_addr       (addr),
    .o_inst       (inst),
    .o_w_mem      (w_mem),
    .o_enable     (enable),
    .o_reset_mips (reset_mips)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] reg_val(input logic [31:0] a);
    return {8'hA5, a[7:0], 8'h5A, ~a[7:0]};
  endfunction

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return {8'hC3, ~a[7:0], 8'h3C, a[7:0]};
  endfunction

  // Pipeline stand-in: PC advances by 4 per enabled cycle; register file and memory have one cycle of read latency.
  always_ff @(posedge clk) begin
    if (rst || reset_mips) pc <= 32'h0;
    else if (enable)       pc <= pc + 32'd4;
    reg_rd <= reg_val(addr);
    mem_rd <= mem_val(addr);
  end

  assign halt = halt_en && (pc == halt_pc);

  // Observe DUT outputs on the falling edge.
  always @(negedge clk) begin
    if (tx_wr) tx_q.push_back(tx_data);
    if (tx_wr && tx_full) bad_wr++;
    if (enable) en_cnt++;
    if (reset_mips) rm_cnt++;
    if (w_mem) begin
      wm_addr.push_back(addr);
      wm_inst.push_back(inst);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input int n, input string tag);
    int cyc;
    cyc = 0;
    while ((tx_q.size() - tx_base) < n && cyc < 3000) begin
      @(posedge clk);
      cyc++;
    end
    repeat (20) @(posedge clk);
    #1;
    chk(tag, 32'(tx_q.size() - tx_base), 32'(n));
  endtask

  function automatic logic [7:0] exp_byte(input int i, input logic [7:0] st, input logic [31:0] pcv);
    logic [31:0] w;
    int k;
    if (i == 0) return st;
    k = (i - 1) / 4;
    if (k == 0)       w = pcv;
    else if (k <= 32) w = reg_val(32'(k - 1));
    else              w = mem_val(32'(k - 33));
    return w[31 - 8 * ((i - 1) % 4) -: 8];
  endfunction

  task automatic check_dump(input logic [7:0] st, input logic [31:0] pcv, input string tag);
    int bad;
    wait_tx(261, {tag, " length"});
    bad = 0;
    if (tx_q.size() - tx_base >= 261) begin
      chk({tag, " status"}, 32'(tx_q[tx_base]), 32'(st));
      chk({tag, " pc"}, {tx_q[tx_base+1], tx_q[tx_base+2], tx_q[tx_base+3], tx_q[tx_base+4]}, pcv);
      for (int i = 0; i < 261; i++)
        if (tx_q[tx_base + i] !== exp_byte(i, st, pcv)) bad++;
    end else begin
      bad = -1;
    end
    chk({tag, " byte errors"}, 32'(bad), 32'd0);
    chk({tag, " addr idle"}, addr, 32'h0);
  endtask

  task automatic expect_ack(input logic [7:0] code, input string tag);
    wait_tx(1, {tag, " length"});
    chk({tag, " code"}, 32'(tx_q[tx_q.size() - 1]), 32'(code));
  endtask

  initial begin
    logic [7:0] ld[10];
    ld = '{8'h4C, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hFC, 8'h00, 8'h00, 8'h00};
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_full = 1'b0;
    halt_en = 1'b0; halt_pc = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset tx_wr", 32'(tx_wr), 32'd0);
    chk("reset tx_data", 32'(tx_data), 32'd0);
    chk("reset w_mem", 32'(w_mem), 32'd0);
    chk("reset inst", inst, 32'h0);
    chk("reset addr", addr, 32'h0);
    chk("reset enable", 32'(enable), 32'd0);
    chk("reset reset_mips", 32'(reset_mips), 32'd0);
    rst = 1'b0;

    // Program load of two words
    tx_base = tx_q.size();
    for (int i = 0; i < 10; i++) send(ld[i]);
    expect_ack(8'h06, "load ack");
    chk("load writes", 32'(wm_addr.size()), 32'd2);
    if (wm_addr.size() >= 2) begin
      chk("load addr0", wm_addr[0], 32'd0);
      chk("load inst0", wm_inst[0], 32'h20080005);
      chk("load addr1", wm_addr[1], 32'd1);
      chk("load inst1", wm_inst[1], 32'hFC000000);
    end

    // Soft reset of the pipeline
    tx_base = tx_q.size(); rm_base = rm_cnt;
    send(8'h52);
    expect_ack(8'h06, "reset ack");
    chk("reset_mips pulses", 32'(rm_cnt - rm_base), 32'd1);

    // Single step
    tx_base = tx_q.size(); en_base = en_cnt;
    send(8'h53);
    check_dump(8'h00, 32'h4, "step");
    chk("step enables", 32'(en_cnt - en_base), 32'd1);

    // Run until halt after 7 enabled cycles
    halt_en = 1'b1; halt_pc = 32'd32;
    tx_base = tx_q.size(); en_base = en_cnt;
    send(8'h43);
    check_dump(8'h01, 32'd32, "run");
    chk("run enables", 32'(en_cnt - en_base), 32'd7);
    halt_en = 1'b0;
    tx_base = tx_q.size();
    send(8'h52);
    expect_ack(8'h06, "reset2 ack");

    // Breakpoint at 0x10, then resume from it until halt at 0x20
    tx_base = tx_q.size();
    send(8'h42); send(8'h00); send(8'h00); send(8'h00); send(8'h10);
    expect_ack(8'h06, "bp ack");
    tx_base = tx_q.size(); en_base = en_cnt;
    send(8'h43);
    check_dump(8'h02, 32'h10, "bp run");
    chk("bp enables", 32'(en_cnt - en_base), 32'd4);
    halt_en = 1'b1; halt_pc = 32'h20;
    tx_base = tx_q.size(); en_base = en_cnt;
    send(8'h43);
    check_dump(8'h01, 32'h20, "bp resume");
    chk("bp resume enables", 32'(en_cnt - en_base), 32'd4);

    // Step on a halted core: no enable cycles, full dump
    tx_base = tx_q.size(); en_base = en_cnt;
    send(8'h53);
    check_dump(8'h01, 32'h20, "halted step");
    chk("halted enables", 32'(en_cnt - en_base), 32'd0);
    halt_en = 1'b0;
    tx_base = tx_q.size();
    send(8'h62);
    expect_ack(8'h06, "bp clear ack");
    tx_base = tx_q.size();
    send(8'h52);
    expect_ack(8'h06, "reset3 ack");

    // Step N with K=5 and K=0
    tx_base = tx_q.size(); en_base = en_cnt;
    send(8'h4E); send(8'h05);
    check_dump(8'h00, 32'h14, "step5");
    chk("step5 enables", 32'(en_cnt - en_base), 32'd5);
    tx_base = tx_q.size(); en_base = en_cnt;
    send(8'h4E); send(8'h00);
    check_dump(8'h00, 32'h14, "step0");
    chk("step0 enables", 32'(en_cnt - en_base), 32'd0);

    // Unknown command byte
    tx_base = tx_q.size();
    send(8'h7A);
    expect_ack(8'h15, "nak");

    // TX backpressure for 10 cycles in the middle of a dump
    tx_base = tx_q.size(); en_base = en_cnt; bad_base = bad_wr;
    send(8'h53);
    for (int c = 0; c < 2000 && (tx_q.size() - tx_base) < 100; c++) @(posedge clk);
    @(posedge clk); #1;
    tx_full = 1'b1;
    stall_base = tx_q.size();
    repeat (10) @(posedge clk);
    #1;
    chk("stall writes", 32'(tx_q.size() - stall_base), 32'd0);
    tx_full = 1'b0;
    check_dump(8'h00, 32'h18, "stall dump");
    chk("stall enables", 32'(en_cnt - en_base), 32'd1);
    chk("write while full", 32'(bad_wr - bad_base), 32'd0);

    // Reset in the middle of a dump aborts it
    send(8'h53);
    repeat (60) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    chk("midreset tx_wr", 32'(tx_wr), 32'd0);
    chk("midreset tx_data", 32'(tx_data), 32'd0);
    chk("midreset addr", addr, 32'h0);
    chk("midreset inst", inst, 32'h0);
    chk("midreset enable", 32'(enable), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    tx_base = tx_q.size();
    send(8'h62);
    expect_ack(8'h06, "post reset ack");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1);
  end

endmodule
